// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned HIGH_CYCLES_DEF = 12_500_000;
    localparam int unsigned LOW_CYCLES_DEF  = 12_500_000;

    // Enough bits to hold the larger of the two phase lengths.
    function automatic int unsigned timer_w(input int unsigned hi, input int unsigned lo);
        int unsigned m;
        m = (hi > lo) ? hi : lo;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_cycle_timer.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-width level pulses with a queued replay.
// Build option PULSE_STRETCHER_EDGE_EN: count only rising edges of Pi (one extra cycle of latency).
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = HIGH_CYCLES_DEF,
    parameter int unsigned LOW_CYCLES  = LOW_CYCLES_DEF,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Pi,
    output logic              Lo,
    output logic              Busy,
    output logic [PEND_W-1:0] Pending,
    output logic              Overflow
);

    localparam int unsigned       TW       = timer_w(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [TW-1:0]     HIGH_LD  = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0]     LOW_LD   = TW'(LOW_CYCLES - 1);

    state_t            state_q, state_d;
    logic              lo_q, lo_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pend_inc, pend_dec;
    logic              tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]     tmr_val;
    logic              ev;

`ifdef PULSE_STRETCHER_EDGE_EN
    logic pi_q, ev_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            pi_q <= 1'b0;
            ev_q <= 1'b0;
        end else begin
            pi_q <= Pi;
            ev_q <= Pi & ~pi_q;
        end
    end

    assign ev = ev_q;
`else
    assign ev = Pi;
`endif

    cycle_timer #(.W(TW)) u_timer (
        .clk_i      (Clk),
        .rst_ni     (ResetN),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = HIGH_LD;
        tmr_en   = 1'b0;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                end
            end
            HIGH: begin
                pend_inc = ev;
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LOW_LD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                pend_inc = ev;
                // An event landing on the expiry edge is queued and consumed at once.
                if (tmr_zero) begin
                    if (pend_q != '0 || ev) begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (pend_inc && !pend_dec) begin
            if (pend_q == PEND_MAX) ovf_d  = 1'b1;
            else                    pend_d = pend_q + 1'b1;
        end else if (pend_dec && !pend_inc) begin
            if (pend_q != '0) pend_d = pend_q - 1'b1;
        end
        lo_d   = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            lo_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign Lo       = lo_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;
    assign Pending  = pend_q;

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart of the button synchronizer's one-shot.
- Accepts single-cycle event pulses in the Clk domain and re-emits each one as a visible level pulse of fixed width on an LED or external pin.
- Pulses arriving while an output pulse is in progress are queued in a saturating pending counter and replayed in order, separated by a guaranteed low gap.

Parameters:
HIGH_CYCLES  12_500_000  output high duration in Clk cycles (250 ms at 50 MHz); must be >= 1
LOW_CYCLES   12_500_000  minimum output low gap between replayed pulses; must be >= 1
PEND_W       4           pending counter width; max queued = 2**PEND_W-1

Ports:
Clk       input   1       system clock, 50 MHz
ResetN    input   1       asynchronous, active-low reset
Pi        input   1       event pulse; synchronous to Clk, sampled every rising edge
Lo        output  1       stretched level output (registered)
Busy      output  1       high in HIGH or GAP state
Pending   output  PEND_W  number of events queued, not yet started
Overflow  output  1       one-cycle pulse when an event is dropped (queue full)

Behaviour:
- Reset: ResetN low forces state IDLE, Lo=0, Busy=0, Pending=0, Overflow=0, timer=0 immediately (asynchronous). Release takes effect at the next Clk edge.
- Reset mid-operation aborts the current pulse and discards the queue; no partial replay follows.
- FSM states:
  - IDLE: Lo=0.
  - HIGH: Lo=1.
  - GAP: Lo=0.
  - Unused encoding: returns to IDLE next cycle.
- IDLE: Pi=1 -> HIGH, timer loaded HIGH_CYCLES-1. Pending unchanged.
- HIGH: timer decrements each cycle. At timer==0 -> GAP, timer loaded LOW_CYCLES-1.
- GAP: timer decrements each cycle. At timer==0:
  - Pending>0 -> HIGH, Pending-1.
  - Pending==0 -> IDLE.
- Latency: Pi high at edge k puts Lo=1 after edge k (IDLE case). Lo is high exactly HIGH_CYCLES cycles.
- Low time between back-to-back replays is exactly LOW_CYCLES cycles.
- From IDLE, a new pulse can start the cycle after GAP ends.
- Pi in HIGH or GAP: Pending+1.
- Pi coinciding with the GAP->HIGH decrement: Pending unchanged (net 0).
- Pi when Pending==max and no decrement in the same cycle: event dropped, Pending holds, Overflow=1 for that cycle.
- Pi held high N cycles without the optional feature counts as N events.
- Busy = (state != IDLE), registered together with the state.
- Timer width = $clog2(max(HIGH_CYCLES, LOW_CYCLES)+1). Timer is an unsigned down-counter with no wrap: it never decrements below 0 because of the state transition.
- Pending arithmetic saturates at both ends. It never wraps.

Optional Feature:
PULSE_STRETCHER_EDGE_EN
- Defined: an internal register detects Pi's rising edge. Only a 0->1 transition counts as an event, so a long Pi high counts once. This adds one cycle of latency: Lo rises one edge later than stated above. The edge register resets to 0.
- Undefined: Pi is used directly; each high cycle is an event.

Decomposition:
- Package pulse_stretcher_pkg:
  - typedef enum logic [1:0] {IDLE=2'd0, HIGH=2'd1, GAP=2'd2} state_t
  - default HIGH_CYCLES/LOW_CYCLES localparams
  - function for timer width
- One sub-module, cycle_timer: loadable down-counter with load, load value, enable and zero flag. It is parameterised by width and has an async active-low reset.
- Pending counter stays inline.

Test Plan (bench uses HIGH_CYCLES=3, LOW_CYCLES=2, PEND_W=2 unless stated):
- Single Pi pulse from IDLE at edge 5 -> Lo=1 on edges 5..7 (3 cycles), then 0. Busy=1 for 5 cycles total, Pending stays 0, Overflow never 1.
- Two Pi pulses at edges 5 and 6 -> Pending=1 from edge 6. Lo: 3 high, 2 low, 3 high. Pending returns to 0 when the second HIGH starts, then IDLE.
- Five Pi pulses on consecutive edges from IDLE -> first starts immediately and Pending climbs to 3. The fifth pulse produces Overflow=1 for exactly one cycle. Exactly 4 Lo pulses follow, each separated by 2 low cycles.
- Pi asserted on the exact edge GAP expires with Pending=1 -> Pending stays 1, HIGH restarts. Total Lo pulses equal total accepted events.
- ResetN dropped during the second cycle of HIGH with Pending=2 -> Lo, Busy and Pending go to 0 without waiting for Clk. After release, no Lo activity occurs until a new Pi.
- PEND_W=3, Pi held high 5 cycles. With PULSE_STRETCHER_EDGE_EN: exactly 1 Lo pulse, starting one cycle later. Without it: 5 Lo pulses and no Overflow.
